// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: LANES columns per cycle over VEC_SIZE/LANES cycles, valid/ready on both sides.
// Define MIXCOL_INV_EN to build the InvMixColumns datapath selected per vector by in_inv.
module mix_columns_iter #(
  parameter int REG_SIZE = 32,
  parameter int VEC_SIZE = 4,
  parameter int LANES    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_inv,
  input  logic [VEC_SIZE-1:0][31:0] in_vect,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_inv,
  output logic [VEC_SIZE-1:0][31:0] out_vect,
  output logic                     busy
);

  localparam int N     = VEC_SIZE / LANES;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if (REG_SIZE != 32) begin : g_bad_reg_size
    $error("mix_columns_iter: REG_SIZE must be 32");
  end
  if ((VEC_SIZE < 1) || (LANES < 1) || ((VEC_SIZE % LANES) != 0)) begin : g_bad_lanes
    $error("mix_columns_iter: LANES must divide VEC_SIZE");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Vectors are stored as N groups of LANES columns so a whole group is addressed by idx.
  typedef logic [N-1:0][LANES-1:0][31:0] grp_vec_t;

  state_t                   state_q;
  logic [IDX_W-1:0]         idx_q;
  grp_vec_t                 src_q;
  grp_vec_t                 res_q;
  logic                     out_valid_q;
  logic                     busy_q;
  logic                     inv_q;
  logic [LANES-1:0][31:0]   grp_d;
  logic                     accept_s;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

`ifdef MIXCOL_INV_EN
  // Multiply by one of the inverse constants 09/0B/0D/0E from its x2/x4/x8 partials.
  function automatic logic [7:0] gmul_inv(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? b2 : 8'h00) ^ (k[2] ? b4 : 8'h00) ^ b8;
  endfunction

  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gmul_inv(a0, 4'he) ^ gmul_inv(a1, 4'hb) ^ gmul_inv(a2, 4'hd) ^ gmul_inv(a3, 4'h9),
            gmul_inv(a0, 4'h9) ^ gmul_inv(a1, 4'he) ^ gmul_inv(a2, 4'hb) ^ gmul_inv(a3, 4'hd),
            gmul_inv(a0, 4'hd) ^ gmul_inv(a1, 4'h9) ^ gmul_inv(a2, 4'he) ^ gmul_inv(a3, 4'hb),
            gmul_inv(a0, 4'hb) ^ gmul_inv(a1, 4'hd) ^ gmul_inv(a2, 4'h9) ^ gmul_inv(a3, 4'he)};
  endfunction
`endif

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept_s  = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_vect  = res_q;

`ifdef MIXCOL_INV_EN
  assign out_inv = inv_q;
`else
  logic unused_inv_s;
  assign unused_inv_s = in_inv;
  assign out_inv      = 1'b0;
`endif

  // Transform the group of columns selected by idx.
  always_comb begin
    grp_d = '0;
    for (int l = 0; l < LANES; l++) begin
`ifdef MIXCOL_INV_EN
      if (inv_q) begin
        grp_d[l] = mix_inv(src_q[idx_q][l]);
      end else begin
        grp_d[l] = mix_fwd(src_q[idx_q][l]);
      end
`else
      grp_d[l] = mix_fwd(src_q[idx_q][l]);
`endif
    end
  end

  // Control FSM plus capture and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      src_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            src_q   <= in_vect;
            inv_q   <= in_inv;
            idx_q   <= '0;
            state_q <= ST_BUSY;
            busy_q  <= 1'b1;
          end
        end
        ST_BUSY: begin
          res_q[idx_q] <= grp_d;
          if (idx_q == IDX_W'(N - 1)) begin
            idx_q       <= '0;
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (accept_s) begin
              src_q   <= in_vect;
              inv_q   <= in_inv;
              idx_q   <= '0;
              state_q <= ST_BUSY;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          idx_q       <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
